// File: rtl/strip_occupancy_table_pkg.sv
// Shared types and constants for the strip occupancy table.
// Holds geometry, the FSM enum and the strip y-base ROM.
package strip_occupancy_table_pkg;

  localparam int NUM_STRIPS = 12;
  localparam int REGION_W   = 128;
  localparam int CNT_W_DEF  = 8;

  localparam logic [3:0] STRIP_NONE = 4'hF;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } state_t;

  // Strip k has height 4+k; base is sum of the heights below it.
  function automatic logic [7:0] y_base(input logic [3:0] k);
    logic [7:0] y;
    y = 8'd0;
    unique case (k)
      4'd0:  y = 8'd0;
      4'd1:  y = 8'd4;
      4'd2:  y = 8'd9;
      4'd3:  y = 8'd15;
      4'd4:  y = 8'd22;
      4'd5:  y = 8'd30;
      4'd6:  y = 8'd39;
      4'd7:  y = 8'd49;
      4'd8:  y = 8'd60;
      4'd9:  y = 8'd72;
      4'd10: y = 8'd85;
      4'd11: y = 8'd99;
      default: y = 8'd0;
    endcase
    return y;
  endfunction

endpackage

// File: rtl/strip_occupancy_table_if.sv
// Request / candidate / write-back / placement bundle.
// master drives requests and write-backs; slave is the table.
interface strip_occupancy_table_if #(
  parameter int CNT_W = 8
);
  logic             req_valid;
  logic             req_ready;
  logic [3:0]       req_height;
  logic [7:0]       req_width;

  logic             cand_valid;
  logic [3:0]       strip_id_1;
  logic [3:0]       strip_id_2;
  logic [3:0]       strip_id_3;
  logic [7:0]       occupied_width_1;
  logic [7:0]       occupied_width_2;
  logic [7:0]       occupied_width_3;
  logic [7:0]       width_out;

  logic             wb_valid;
  logic [3:0]       wb_strip_id;
  logic [7:0]       wb_old_width;
  logic [7:0]       wb_new_width;
  logic             wb_strike;

  logic             place_valid;
  logic             place_strike;
  logic [7:0]       place_x;
  logic [7:0]       place_y;
  logic [CNT_W-1:0] strike_count;
  logic             proto_err;

  modport master (
    output req_valid, req_height, req_width,
    output wb_valid, wb_strip_id, wb_old_width,
    output wb_new_width, wb_strike,
    input  req_ready, cand_valid,
    input  strip_id_1, strip_id_2, strip_id_3,
    input  occupied_width_1, occupied_width_2,
    input  occupied_width_3, width_out,
    input  place_valid, place_strike,
    input  place_x, place_y,
    input  strike_count, proto_err
  );

  modport slave (
    input  req_valid, req_height, req_width,
    input  wb_valid, wb_strip_id, wb_old_width,
    input  wb_new_width, wb_strike,
    output req_ready, cand_valid,
    output strip_id_1, strip_id_2, strip_id_3,
    output occupied_width_1, occupied_width_2,
    output occupied_width_3, width_out,
    output place_valid, place_strike,
    output place_x, place_y,
    output strike_count, proto_err
  );

endinterface

// File: rtl/strip_occupancy_table_lut.sv
// Combinational height -> three candidate strips (h-4..h-2).
// Ports: height in; id_1..3 (STRIP_NONE if absent), vld_1..3 out.
module strip_candidate_lut
  import strip_occupancy_table_pkg::*;
(
  input  logic [3:0] height,
  output logic [3:0] id_1,
  output logic [3:0] id_2,
  output logic [3:0] id_3,
  output logic       vld_1,
  output logic       vld_2,
  output logic       vld_3
);

  logic       in_rng;
  logic [4:0] i0;
  logic [4:0] i1;
  logic [4:0] i2;

  assign in_rng = height >= 4'd4;
  assign i0     = {1'b0, height} - 5'd4;
  assign i1     = i0 + 5'd1;
  assign i2     = i0 + 5'd2;

  assign vld_1 = in_rng && (i0 < 5'(NUM_STRIPS));
  assign vld_2 = in_rng && (i1 < 5'(NUM_STRIPS));
  assign vld_3 = in_rng && (i2 < 5'(NUM_STRIPS));

  assign id_1 = vld_1 ? i0[3:0] : STRIP_NONE;
  assign id_2 = vld_2 ? i1[3:0] : STRIP_NONE;
  assign id_3 = vld_3 ? i2[3:0] : STRIP_NONE;

endmodule

// File: rtl/strip_occupancy_table.sv
// Per-strip occupancy table: issues candidates, commits write-backs.
// Ports: clk, rst (sync, active-low), bus (slave side of the bundle).
module strip_occupancy_table
  import strip_occupancy_table_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF
)(
  input  logic                   clk,
  input  logic                   rst,
  strip_occupancy_table_if.slave bus
);

  state_t state;
  state_t state_nx;

  logic [7:0] occ [NUM_STRIPS];

  logic [3:0] c_id_1;
  logic [3:0] c_id_2;
  logic [3:0] c_id_3;
  logic       c_v_1;
  logic       c_v_2;
  logic       c_v_3;

  logic       hs;
  logic       wb_fmt_err;
  logic       wb_commit;
  logic       wb_err;

  logic       ready_d;
  logic       cand_d;
  logic       place_d;

  logic             ready_q;
  logic             cand_q;
  logic [3:0]       id_1_q;
  logic [3:0]       id_2_q;
  logic [3:0]       id_3_q;
  logic [7:0]       ow_1_q;
  logic [7:0]       ow_2_q;
  logic [7:0]       ow_3_q;
  logic [7:0]       wout_q;
  logic             place_q;
  logic             strike_q;
  logic [7:0]       x_q;
  logic [7:0]       y_q;
  logic [CNT_W-1:0] cnt_q;
  logic             err_q;

  strip_candidate_lut u_lut (
    .height (bus.req_height),
    .id_1   (c_id_1),
    .id_2   (c_id_2),
    .id_3   (c_id_3),
    .vld_1  (c_v_1),
    .vld_2  (c_v_2),
    .vld_3  (c_v_3)
  );

  assign hs = bus.req_valid & ready_q;

  // A bad id or width is only meaningful for a real placement.
  assign wb_fmt_err = ~bus.wb_strike &
    ((bus.wb_strip_id >= 4'(NUM_STRIPS)) |
     (bus.wb_new_width > 8'(REGION_W)));

  assign wb_commit = bus.wb_valid & (state == WAIT) & ~wb_fmt_err;
  assign wb_err    = bus.wb_valid & ((state != WAIT) | wb_fmt_err);

  always_ff @(posedge clk) begin
    if (!rst) state <= IDLE;
    else      state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (hs) state_nx = ISSUE;
      ISSUE:   state_nx = WAIT;
      WAIT:    if (wb_commit) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    ready_d = (state_nx == IDLE);
    cand_d  = (state_nx == ISSUE);
    place_d = wb_commit;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < NUM_STRIPS; i++) occ[i] <= 8'd0;
      ready_q  <= 1'b1;
      cand_q   <= 1'b0;
      id_1_q   <= 4'd0;
      id_2_q   <= 4'd0;
      id_3_q   <= 4'd0;
      ow_1_q   <= 8'd0;
      ow_2_q   <= 8'd0;
      ow_3_q   <= 8'd0;
      wout_q   <= 8'd0;
      place_q  <= 1'b0;
      strike_q <= 1'b0;
      x_q      <= 8'd0;
      y_q      <= 8'd0;
      cnt_q    <= '0;
      err_q    <= 1'b0;
    end else begin
      ready_q <= ready_d;
      cand_q  <= cand_d;
      place_q <= place_d;
      if (hs) begin
        id_1_q <= c_id_1;
        id_2_q <= c_id_2;
        id_3_q <= c_id_3;
        ow_1_q <= c_v_1 ? occ[c_id_1] : 8'(REGION_W);
        ow_2_q <= c_v_2 ? occ[c_id_2] : 8'(REGION_W);
        ow_3_q <= c_v_3 ? occ[c_id_3] : 8'(REGION_W);
        wout_q <= bus.req_width;
      end
      if (wb_commit) begin
        strike_q <= bus.wb_strike;
        if (bus.wb_strike) begin
          x_q <= 8'd0;
          y_q <= 8'd0;
          if (cnt_q != '1) cnt_q <= cnt_q + 1'b1;
        end else begin
          x_q <= bus.wb_old_width;
          y_q <= y_base(bus.wb_strip_id);
          occ[bus.wb_strip_id] <= bus.wb_new_width;
        end
      end
      if (wb_err) err_q <= 1'b1;
    end
  end

  assign bus.req_ready        = ready_q;
  assign bus.cand_valid       = cand_q;
  assign bus.strip_id_1       = id_1_q;
  assign bus.strip_id_2       = id_2_q;
  assign bus.strip_id_3       = id_3_q;
  assign bus.occupied_width_1 = ow_1_q;
  assign bus.occupied_width_2 = ow_2_q;
  assign bus.occupied_width_3 = ow_3_q;
  assign bus.width_out        = wout_q;
  assign bus.place_valid      = place_q;
  assign bus.place_strike     = strike_q;
  assign bus.place_x          = x_q;
  assign bus.place_y          = y_q;
  assign bus.strike_count     = cnt_q;
  assign bus.proto_err        = err_q;

endmodule

// File: tb/tb_strip_occupancy_table.sv
// Directed bench for strip_occupancy_table.
// Hand-computed expectations; one checker task counts all compares.
module tb_strip_occupancy_table;

  logic clk;
  logic rst;
  int   total;
  int   bad;

  strip_occupancy_table_if #(.CNT_W(8)) bus ();

  strip_occupancy_table #(.CNT_W(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_req(input logic [3:0] h,
                        input logic [7:0] w);
    bus.req_valid  = 1'b1;
    bus.req_height = h;
    bus.req_width  = w;
    step();
    bus.req_valid  = 1'b0;
  endtask

  task automatic do_wb(input logic [3:0] id,
                       input logic [7:0] ow,
                       input logic [7:0] nw,
                       input logic       s);
    bus.wb_valid     = 1'b1;
    bus.wb_strip_id  = id;
    bus.wb_old_width = ow;
    bus.wb_new_width = nw;
    bus.wb_strike    = s;
    step();
    bus.wb_valid     = 1'b0;
  endtask

  task automatic chk_cand(input string t,
                          input logic [3:0] i1,
                          input logic [3:0] i2,
                          input logic [3:0] i3,
                          input logic [7:0] w1,
                          input logic [7:0] w2,
                          input logic [7:0] w3,
                          input logic [7:0] wo);
    chk({t, ".cv"},  32'(bus.cand_valid), 1);
    chk({t, ".id1"}, 32'(bus.strip_id_1), 32'(i1));
    chk({t, ".id2"}, 32'(bus.strip_id_2), 32'(i2));
    chk({t, ".id3"}, 32'(bus.strip_id_3), 32'(i3));
    chk({t, ".w1"},  32'(bus.occupied_width_1), 32'(w1));
    chk({t, ".w2"},  32'(bus.occupied_width_2), 32'(w2));
    chk({t, ".w3"},  32'(bus.occupied_width_3), 32'(w3));
    chk({t, ".wo"},  32'(bus.width_out), 32'(wo));
    chk({t, ".rdy"}, 32'(bus.req_ready), 0);
  endtask

  task automatic chk_place(input string t,
                           input logic       s,
                           input logic [7:0] x,
                           input logic [7:0] y);
    chk({t, ".pv"},  32'(bus.place_valid), 1);
    chk({t, ".rdy"}, 32'(bus.req_ready), 1);
    chk({t, ".ps"},  32'(bus.place_strike), 32'(s));
    chk({t, ".x"},   32'(bus.place_x), 32'(x));
    chk({t, ".y"},   32'(bus.place_y), 32'(y));
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst   = 1'b0;
    bus.req_valid    = 1'b0;
    bus.req_height   = 4'd0;
    bus.req_width    = 8'd0;
    bus.wb_valid     = 1'b0;
    bus.wb_strip_id  = 4'd0;
    bus.wb_old_width = 8'd0;
    bus.wb_new_width = 8'd0;
    bus.wb_strike    = 1'b0;
    step();
    step();
    chk("rst.rdy", 32'(bus.req_ready), 1);
    chk("rst.cv",  32'(bus.cand_valid), 0);
    chk("rst.pv",  32'(bus.place_valid), 0);
    chk("rst.ps",  32'(bus.place_strike), 0);
    chk("rst.err", 32'(bus.proto_err), 0);
    chk("rst.cnt", 32'(bus.strike_count), 0);
    chk("rst.id1", 32'(bus.strip_id_1), 0);
    chk("rst.x",   32'(bus.place_x), 0);
    rst = 1'b1;
    step();

    do_req(4'd4, 8'd10);
    chk_cand("t1", 4'd0, 4'd1, 4'd2, 8'd0, 8'd0, 8'd0, 8'd10);
    step();
    chk("t1.cv_pulse", 32'(bus.cand_valid), 0);
    do_wb(4'd0, 8'd0, 8'd10, 1'b0);
    chk_place("t1", 1'b0, 8'd0, 8'd0);
    step();
    chk("t1.pv_pulse", 32'(bus.place_valid), 0);

    do_req(4'd4, 8'd20);
    chk_cand("t2", 4'd0, 4'd1, 4'd2, 8'd10, 8'd0, 8'd0, 8'd20);
    step();
    chk("t2.rdy_w0", 32'(bus.req_ready), 0);
    // a request held while busy must not be taken
    bus.req_valid  = 1'b1;
    bus.req_height = 4'd5;
    step();
    chk("t2.rdy_w1", 32'(bus.req_ready), 0);
    chk("t2.hold_cv", 32'(bus.cand_valid), 0);
    bus.req_valid = 1'b0;
    do_wb(4'd1, 8'd0, 8'd20, 1'b0);
    chk_place("t2", 1'b0, 8'd0, 8'd4);
    step();

    do_req(4'd14, 8'd5);
    chk_cand("t3", 4'd10, 4'd11, 4'hF, 8'd0, 8'd0, 8'd128, 8'd5);
    step();
    do_wb(4'd11, 8'd0, 8'd5, 1'b0);
    chk_place("t3", 1'b0, 8'd0, 8'd99);
    step();

    do_req(4'd2, 8'd7);
    chk_cand("t4", 4'hF, 4'hF, 4'hF, 8'd128, 8'd128, 8'd128, 8'd7);
    step();
    do_wb(4'd3, 8'd50, 8'd60, 1'b1);
    chk_place("t4", 1'b1, 8'd0, 8'd0);
    chk("t4.cnt", 32'(bus.strike_count), 1);
    step();

    do_req(4'd4, 8'd1);
    chk_cand("t5", 4'd0, 4'd1, 4'd2, 8'd10, 8'd20, 8'd0, 8'd1);
    step();
    do_wb(4'd0, 8'd0, 8'd0, 1'b1);
    step();

    do_req(4'd15, 8'd128);
    chk_cand("t6", 4'd11, 4'hF, 4'hF, 8'd5, 8'd128, 8'd128, 8'd128);
    step();
    do_wb(4'd0, 8'd0, 8'd0, 1'b1);
    chk("t6.cnt", 32'(bus.strike_count), 3);
    step();

    // 252 more strikes reach 255 exactly, the rest must saturate
    for (int i = 0; i < 300; i++) begin
      do_req(4'd2, 8'd1);
      step();
      do_wb(4'd0, 8'd0, 8'd0, 1'b1);
      step();
      if (i == 251) chk("sat.255", 32'(bus.strike_count), 255);
    end
    chk("sat.end", 32'(bus.strike_count), 255);
    chk("sat.err", 32'(bus.proto_err), 0);

    do_wb(4'd0, 8'd0, 8'd99, 1'b0);
    chk("idle.err", 32'(bus.proto_err), 1);
    chk("idle.pv",  32'(bus.place_valid), 0);
    chk("idle.rdy", 32'(bus.req_ready), 1);
    step();
    do_req(4'd4, 8'd3);
    chk_cand("t7", 4'd0, 4'd1, 4'd2, 8'd10, 8'd20, 8'd0, 8'd3);
    step();

    // reset while waiting, with a valid write-back in the same cycle
    rst = 1'b0;
    bus.wb_valid     = 1'b1;
    bus.wb_strip_id  = 4'd0;
    bus.wb_old_width = 8'd10;
    bus.wb_new_width = 8'd77;
    bus.wb_strike    = 1'b0;
    step();
    rst = 1'b1;
    bus.wb_valid = 1'b0;
    chk("rw.rdy", 32'(bus.req_ready), 1);
    chk("rw.pv",  32'(bus.place_valid), 0);
    chk("rw.err", 32'(bus.proto_err), 0);
    chk("rw.cnt", 32'(bus.strike_count), 0);
    step();
    do_req(4'd4, 8'd9);
    chk_cand("t8", 4'd0, 4'd1, 4'd2, 8'd0, 8'd0, 8'd0, 8'd9);
    step();

    do_wb(4'd12, 8'd0, 8'd9, 1'b0);
    chk("id12.err", 32'(bus.proto_err), 1);
    chk("id12.pv",  32'(bus.place_valid), 0);
    chk("id12.rdy", 32'(bus.req_ready), 0);
    do_wb(4'd0, 8'd0, 8'd129, 1'b0);
    chk("w129.pv",  32'(bus.place_valid), 0);
    chk("w129.rdy", 32'(bus.req_ready), 0);
    do_wb(4'd2, 8'd0, 8'd128, 1'b0);
    chk_place("t9", 1'b0, 8'd0, 8'd9);
    step();
    do_req(4'd4, 8'd2);
    chk_cand("t10", 4'd0, 4'd1, 4'd2, 8'd0, 8'd0, 8'd128, 8'd2);
    step();
    do_wb(4'd0, 8'd0, 8'd2, 1'b1);
    chk("t10.err", 32'(bus.proto_err), 1);
    step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
